hazard_ctrl: RTL

- Pipeline hazard controller for the 5-stage core.
- Generates the 2-bit select codes for the two execute-stage operand forwarding 4:1 muxes.
- Generates stall and flush strobes for load-use hazards, taken branches and multi-cycle data-memory waits.
- Sequences an operand-hold capture so a writeback result is not lost while the pipeline is frozen, and times out hung memory accesses.

---
 rtl/hazard_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: execute-stage forwarding selects, stall/flush strobes,
// operand-hold sequencing across data-memory waits, and a sticky memory-timeout trap.

module hazard_fwd_sel #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CONTROL_WIDTH  = 2
) (
    input  logic [REG_ADDR_WIDTH-1:0] i_rs,
    input  logic [REG_ADDR_WIDTH-1:0] i_rdM,
    input  logic                      i_regwriteM,
    input  logic [REG_ADDR_WIDTH-1:0] i_rdW,
    input  logic                      i_regwriteW,
    input  logic                      i_hold_valid,
    output logic [CONTROL_WIDTH-1:0]  o_sel
);
    localparam logic [CONTROL_WIDTH-1:0] FWD_RF   = CONTROL_WIDTH'(0);
    localparam logic [CONTROL_WIDTH-1:0] FWD_WB   = CONTROL_WIDTH'(1);
    localparam logic [CONTROL_WIDTH-1:0] FWD_MEM  = CONTROL_WIDTH'(2);
    localparam logic [CONTROL_WIDTH-1:0] FWD_HOLD = CONTROL_WIDTH'(3);

    logic w_hit_m;
    logic w_hit_w;

    assign w_hit_m = i_regwriteM && (i_rdM != '0) && (i_rdM == i_rs);
    assign w_hit_w = i_regwriteW && (i_rdW != '0) && (i_rdW == i_rs);

    // The captured hold value is older than M but newer than the regfile/W path
    // once the pipeline has been frozen, hence its slot in the priority order.
    always_comb begin
        o_sel = FWD_RF;
        if (w_hit_m)           o_sel = FWD_MEM;
        else if (i_hold_valid) o_sel = FWD_HOLD;
        else if (w_hit_w)      o_sel = FWD_WB;
    end
endmodule

module hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CONTROL_WIDTH  = 2,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] rs1D,
    input  logic [REG_ADDR_WIDTH-1:0] rs2D,
    input  logic [REG_ADDR_WIDTH-1:0] rs1E,
    input  logic [REG_ADDR_WIDTH-1:0] rs2E,
    input  logic [REG_ADDR_WIDTH-1:0] rdE,
    input  logic                      loadE,
    input  logic                      pcsrcE,
    input  logic [REG_ADDR_WIDTH-1:0] rdM,
    input  logic                      regwriteM,
    input  logic [REG_ADDR_WIDTH-1:0] rdW,
    input  logic                      regwriteW,
    input  logic                      dmem_busy,
    output logic [CONTROL_WIDTH-1:0]  forwardAE,
    output logic [CONTROL_WIDTH-1:0]  forwardBE,
    output logic                      hold_a_en,
    output logic                      hold_b_en,
    output logic                      stallF,
    output logic                      stallD,
    output logic                      stallE,
    output logic                      stallM,
    output logic                      flushD,
    output logic                      flushE,
    output logic                      flushW,
    output logic                      mem_timeout
);
    localparam int NUM_OPS = 2;
    localparam logic [CONTROL_WIDTH-1:0] FWD_WB  = CONTROL_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]     CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t                              r_state, w_state_nxt;
    logic [CNT_WIDTH-1:0]                r_cnt, w_cnt_nxt;
    logic [NUM_OPS-1:0]                  r_hold_valid, w_hold_valid_nxt;
    logic                                r_mem_timeout, w_mem_timeout_nxt;

    logic [NUM_OPS-1:0][REG_ADDR_WIDTH-1:0] w_rs;
    logic [NUM_OPS-1:0][CONTROL_WIDTH-1:0]  w_sel;
    logic [NUM_OPS-1:0]                     w_hold_en;
    logic                                   w_frozen;
    logic                                   w_load_use;

    assign w_rs = {rs2E, rs1E};

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
        hazard_fwd_sel #(
            .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
            .CONTROL_WIDTH  (CONTROL_WIDTH)
        ) u_sel (
            .i_rs         (w_rs[g]),
            .i_rdM        (rdM),
            .i_regwriteM  (regwriteM),
            .i_rdW        (rdW),
            .i_regwriteW  (regwriteW),
            .i_hold_valid (r_hold_valid[g]),
            .o_sel        (w_sel[g])
        );
        // Capture only on the cycle the freeze begins; W is bubbled afterwards.
        assign w_hold_en[g] = (r_state == ST_RUN) && dmem_busy && (w_sel[g] == FWD_WB);
    end

    assign forwardAE   = w_sel[0];
    assign forwardBE   = w_sel[1];
    assign hold_a_en   = w_hold_en[0];
    assign hold_b_en   = w_hold_en[1];
    assign mem_timeout = r_mem_timeout;

    assign w_load_use = loadE && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));
    assign w_frozen   = (r_state == ST_ERR) || dmem_busy;

    // A frozen pipeline must not bubble D/E: the branch or load-use is
    // re-evaluated on the exit cycle since E is still holding the same instruction.
    always_comb begin
        stallF = w_frozen | w_load_use;
        stallD = w_frozen | w_load_use;
        stallE = w_frozen;
        stallM = w_frozen;
        flushD = !w_frozen && pcsrcE;
        flushE = !w_frozen && (pcsrcE || w_load_use);
        flushW = w_frozen;
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_hold_valid_nxt  = r_hold_valid;
        w_mem_timeout_nxt = r_mem_timeout;
        case (r_state)
            ST_RUN: begin
                if (dmem_busy) begin
                    w_state_nxt      = ST_WAIT;
                    w_cnt_nxt        = CNT_WIDTH'(1);
                    w_hold_valid_nxt = r_hold_valid | w_hold_en;
                end
            end
            ST_WAIT: begin
                if (dmem_busy) begin
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt       = ST_ERR;
                        w_mem_timeout_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
                    end
                end else begin
                    w_state_nxt      = ST_RUN;
                    w_cnt_nxt        = '0;
                    w_hold_valid_nxt = '0;
                end
            end
            ST_ERR: begin
                w_state_nxt = ST_ERR;
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_cnt         <= '0;
            r_hold_valid  <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_hold_valid  <= w_hold_valid_nxt;
            r_mem_timeout <= w_mem_timeout_nxt;
        end
    end
endmodule
